palindrome_arbiter: RTL and testbench

- Shares a single combinational palindrome check among NUM_REQ requesters.
- Round-robin arbitration. A one-entry registered response stage with valid/ready backpressure. Saturating statistics counters.
- Sits between producer ports (e.g. test-pattern sources) and one consumer that reads verdicts tagged with the requester ID.

---
 rtl/palindrome_pkg.sv | 27 ++
 rtl/palindrome_core.sv | 19 +
 rtl/palindrome_arbiter.sv | 122 ++++++++++++
 tb/tb_palindrome_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/palindrome_pkg.sv
// rtl/palindrome_pkg.sv - shared types and helpers for the palindrome arbiter
package palindrome_pkg;

    // Output stage occupancy: EMPTY means no response is held
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    // ID width helper: at least one bit even for a single requester
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int DEFAULT_NUM_REQ    = 4;
    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ID_WIDTH   = clog2_min1(DEFAULT_NUM_REQ);

    // Response view at the default geometry, for consumers built at defaults;
    // the arbiter itself uses an equivalent struct sized by its parameters
    typedef struct packed {
        logic [DEFAULT_ID_WIDTH-1:0]   id;
        logic                          is_pal;
        logic [DEFAULT_DATA_WIDTH-1:0] data;
    } rsp_t;

endpackage

// File: rtl/palindrome_core.sv
// rtl/palindrome_core.sv - combinational bit-palindrome check
module palindrome_core #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  is_pal
);

    // Compare mirrored bit pairs; an odd middle bit has no partner and is ignored
    always_comb begin
        is_pal = 1'b1;
        for (int i = 0; i < DATA_WIDTH / 2; i++) begin
            if (din[i] != din[DATA_WIDTH-1-i]) begin
                is_pal = 1'b0;
            end
        end
    end

endmodule

// File: rtl/palindrome_arbiter.sv
// rtl/palindrome_arbiter.sv - round-robin shared palindrome checker with registered response
module palindrome_arbiter
    import palindrome_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16,
    localparam int ID_W      = clog2_min1(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ID_W-1:0]               rsp_id,
    output logic                          rsp_is_pal,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    input  logic                          stat_clear,
    output logic [CNT_WIDTH-1:0]          pal_count,
    output logic [CNT_WIDTH-1:0]          total_count
);

    typedef struct packed {
        logic [ID_W-1:0]       id;
        logic                  is_pal;
        logic [DATA_WIDTH-1:0] data;
    } rsp_reg_t;

    state_e                state;
    rsp_reg_t              rsp_q;
    logic [ID_W-1:0]       ptr;

    logic                  can_accept;
    logic                  gnt_found;
    logic [NUM_REQ-1:0]    gnt_onehot;
    logic [ID_W-1:0]       gnt_id;
    logic [ID_W-1:0]       ptr_next;
    logic [DATA_WIDTH-1:0] gnt_data;
    logic                  gnt_is_pal;
    logic                  grant;
    logic                  rsp_hs;
    int                    idx;
    int                    nxt;

    assign can_accept = (state == EMPTY) || rsp_ready;
    assign grant      = can_accept && gnt_found;
    assign req_ready  = can_accept ? gnt_onehot : '0;
    assign rsp_hs     = (state == FULL) && rsp_ready;

    // Round-robin search starting at ptr; also muxes the winning word and next pointer
    always_comb begin
        gnt_found  = 1'b0;
        gnt_onehot = '0;
        gnt_id     = '0;
        gnt_data   = '0;
        ptr_next   = ptr;
        idx        = 0;
        nxt        = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!gnt_found && req_valid[idx]) begin
                gnt_found       = 1'b1;
                gnt_onehot[idx] = 1'b1;
                gnt_id          = ID_W'(idx);
                gnt_data        = req_data[idx*DATA_WIDTH +: DATA_WIDTH];
                nxt             = (idx + 1 >= NUM_REQ) ? 0 : idx + 1;
                ptr_next        = ID_W'(nxt);
            end
        end
    end

    palindrome_core #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_core (
        .din    (gnt_data),
        .is_pal (gnt_is_pal)
    );

    // Output register: load on grant, drain on consumer accept, otherwise hold
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= EMPTY;
            rsp_q <= '0;
            ptr   <= '0;
        end else if (grant) begin
            state <= FULL;
            rsp_q <= '{id: gnt_id, is_pal: gnt_is_pal, data: gnt_data};
            ptr   <= ptr_next;
        end else if (rsp_ready) begin
            state <= EMPTY;
        end
    end

    // Saturating statistics; clear wins over a same-cycle increment
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            total_count <= '0;
            pal_count   <= '0;
        end else if (stat_clear) begin
            total_count <= '0;
            pal_count   <= '0;
        end else if (rsp_hs) begin
            if (total_count != '1) begin
                total_count <= total_count + 1'b1;
            end
            if (rsp_q.is_pal && (pal_count != '1)) begin
                pal_count <= pal_count + 1'b1;
            end
        end
    end

    assign rsp_valid  = (state == FULL);
    assign rsp_id     = rsp_q.id;
    assign rsp_is_pal = rsp_q.is_pal;
    assign rsp_data   = rsp_q.data;

endmodule

// File: tb/tb_palindrome_arbiter.sv
// tb/tb_palindrome_arbiter.sv - self-checking bench for palindrome_arbiter
module tb_palindrome_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int CW = 16;
    localparam int IW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetn;

    logic [NR-1:0]    req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_ready;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [IW-1:0]    rsp_id;
    logic             rsp_is_pal;
    logic [DW-1:0]    rsp_data;
    logic             stat_clear;
    logic [CW-1:0]    pal_count;
    logic [CW-1:0]    total_count;

    logic [1:0]  s_req_valid;
    logic [9:0]  s_req_data;
    logic [1:0]  s_req_ready;
    logic        s_rsp_valid;
    logic        s_rsp_ready;
    logic [0:0]  s_rsp_id;
    logic        s_rsp_is_pal;
    logic [4:0]  s_rsp_data;
    logic        s_stat_clear;
    logic [3:0]  s_pal_count;
    logic [3:0]  s_total_count;

    logic [0:0]  t_req_valid;
    logic [0:0]  t_req_data;
    logic [0:0]  t_req_ready;
    logic        t_rsp_valid;
    logic        t_rsp_ready;
    logic [0:0]  t_rsp_id;
    logic        t_rsp_is_pal;
    logic [0:0]  t_rsp_data;
    logic        t_stat_clear;
    logic [3:0]  t_pal_count;
    logic [3:0]  t_total_count;

    int checks = 0;
    int errors = 0;

    palindrome_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_is_pal(rsp_is_pal), .rsp_data(rsp_data),
        .stat_clear(stat_clear), .pal_count(pal_count), .total_count(total_count)
    );

    palindrome_arbiter #(.NUM_REQ(2), .DATA_WIDTH(5), .CNT_WIDTH(4)) dut_small (
        .clk(clk), .resetn(resetn),
        .req_valid(s_req_valid), .req_data(s_req_data), .req_ready(s_req_ready),
        .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_id(s_rsp_id),
        .rsp_is_pal(s_rsp_is_pal), .rsp_data(s_rsp_data),
        .stat_clear(s_stat_clear), .pal_count(s_pal_count), .total_count(s_total_count)
    );

    palindrome_arbiter #(.NUM_REQ(1), .DATA_WIDTH(1), .CNT_WIDTH(4)) dut_tiny (
        .clk(clk), .resetn(resetn),
        .req_valid(t_req_valid), .req_data(t_req_data), .req_ready(t_req_ready),
        .rsp_valid(t_rsp_valid), .rsp_ready(t_rsp_ready), .rsp_id(t_rsp_id),
        .rsp_is_pal(t_rsp_is_pal), .rsp_data(t_rsp_data),
        .stat_clear(t_stat_clear), .pal_count(t_pal_count), .total_count(t_total_count)
    );

    // Reference rule: a word is a palindrome iff it equals its own bit reversal
    function automatic logic ref_pal(input logic [DW-1:0] d);
        logic [DW-1:0] r;
        r = {<<{d}};
        return d == r;
    endfunction

    task automatic clear_inputs();
        req_valid = '0; req_data = '0; rsp_ready = 1'b0; stat_clear = 1'b0;
        s_req_valid = '0; s_req_data = '0; s_rsp_ready = 1'b0; s_stat_clear = 1'b0;
        t_req_valid = '0; t_req_data = '0; t_rsp_ready = 1'b0; t_stat_clear = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %0b exp 0", rsp_valid); end
        checks++; if (rsp_id !== '0) begin errors++; $display("FAIL reset_rsp_id got %0d exp 0", rsp_id); end
        checks++; if (rsp_is_pal !== 1'b0) begin errors++; $display("FAIL reset_rsp_is_pal got %0b exp 0", rsp_is_pal); end
        checks++; if (rsp_data !== '0) begin errors++; $display("FAIL reset_rsp_data got %h exp 0", rsp_data); end
        checks++; if (total_count !== '0 || pal_count !== '0) begin errors++; $display("FAIL reset_counts got %0d/%0d exp 0/0", total_count, pal_count); end
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready got %b exp 0000", req_ready); end
        checks++; if (s_rsp_valid !== 1'b0 || t_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_small_valid got %0b%0b exp 00", s_rsp_valid, t_rsp_valid); end
        @(negedge clk);
    endtask

    task automatic test_single();
        do_reset();
        rsp_ready = 1'b1;
        req_valid = 4'b0001;
        req_data[31:0] = 32'h8000_0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_req_ready got %b exp 0001", req_ready); end
        @(posedge clk); @(negedge clk);
        req_valid = '0;
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_is_pal !== 1'b1) begin
            errors++; $display("FAIL single_rsp got v%0b id%0d pal%0b exp v1 id0 pal1", rsp_valid, rsp_id, rsp_is_pal); end
        checks++; if (rsp_data !== 32'h8000_0001) begin errors++; $display("FAIL single_rsp_data got %h exp 80000001", rsp_data); end
        @(posedge clk); @(negedge clk);
        checks++; if (total_count !== 16'd1 || pal_count !== 16'd1) begin
            errors++; $display("FAIL single_counts got %0d/%0d exp 1/1", total_count, pal_count); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %0b exp 0", rsp_valid); end
    endtask

    task automatic test_round_robin();
        do_reset();
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = {8'(i + 1), 24'h00_0000};
        for (int k = 0; k < 9; k++) begin
            #1;
            checks++; if (req_ready !== 4'(1 << (k % NR))) begin
                errors++; $display("FAIL rr_grant cycle %0d got %b exp %b", k, req_ready, 4'(1 << (k % NR))); end
            @(posedge clk); @(negedge clk);
            checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(k % NR) || rsp_data !== {8'((k % NR) + 1), 24'h00_0000}) begin
                errors++; $display("FAIL rr_rsp cycle %0d got v%0b id%0d data %h exp id%0d", k, rsp_valid, rsp_id, rsp_data, k % NR); end
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        do_reset();
        rsp_ready = 1'b1;
        req_valid = 4'b0001;
        req_data[31:0] = 32'h0000_0002;
        @(posedge clk); @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = 32'hA5A5_0000 + 32'(i);
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready cycle %0d got %b exp 0000", k, req_ready); end
            @(posedge clk); @(negedge clk);
            checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_is_pal !== 1'b0 || rsp_data !== 32'h0000_0002) begin
                errors++; $display("FAIL bp_hold cycle %0d got v%0b id%0d pal%0b data %h exp v1 id0 pal0 00000002", k, rsp_valid, rsp_id, rsp_is_pal, rsp_data); end
        end
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_release_ready got %b exp 0010", req_ready); end
        @(posedge clk); @(negedge clk);
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 32'hA5A5_0001) begin
            errors++; $display("FAIL bp_release_rsp got v%0b id%0d data %h exp v1 id1 a5a50001", rsp_valid, rsp_id, rsp_data); end
        checks++; if (total_count !== 16'd1) begin errors++; $display("FAIL bp_total got %0d exp 1", total_count); end
        req_valid = '0;
    endtask

    task automatic test_widths();
        logic [4:0] vals [5];
        logic       exps [5];
        vals[0] = 5'b10101; exps[0] = 1'b1;
        vals[1] = 5'b10001; exps[1] = 1'b1;
        vals[2] = 5'b10011; exps[2] = 1'b0;
        vals[3] = 5'b00100; exps[3] = 1'b1;
        vals[4] = 5'b01000; exps[4] = 1'b0;
        do_reset();
        s_rsp_ready = 1'b1;
        s_req_valid = 2'b01;
        for (int k = 0; k < 5; k++) begin
            s_req_data[4:0] = vals[k];
            @(posedge clk); @(negedge clk);
            checks++; if (s_rsp_is_pal !== exps[k] || s_rsp_data !== vals[k]) begin
                errors++; $display("FAIL w5_pal val %b got pal%0b data %b exp pal%0b", vals[k], s_rsp_is_pal, s_rsp_data, exps[k]); end
        end
        s_req_valid = '0;
        t_rsp_ready = 1'b1;
        t_req_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            t_req_data = 1'(k);
            @(posedge clk); @(negedge clk);
            checks++; if (t_rsp_valid !== 1'b1 || t_rsp_is_pal !== 1'b1 || t_rsp_data !== 1'(k)) begin
                errors++; $display("FAIL w1_pal val %0d got v%0b pal%0b exp v1 pal1", k, t_rsp_valid, t_rsp_is_pal); end
        end
        t_req_valid = '0;
    endtask

    task automatic test_saturate();
        do_reset();
        s_rsp_ready = 1'b1;
        s_req_valid = 2'b11;
        s_req_data = {5'b10001, 5'b10001};
        repeat (22) @(negedge clk);
        checks++; if (s_total_count !== 4'd15 || s_pal_count !== 4'd15) begin
            errors++; $display("FAIL sat_counts got %0d/%0d exp 15/15", s_total_count, s_pal_count); end
        s_stat_clear = 1'b1;
        #1;
        checks++; if (s_rsp_valid !== 1'b1) begin errors++; $display("FAIL sat_clear_hs got %0b exp 1", s_rsp_valid); end
        @(posedge clk); @(negedge clk);
        s_stat_clear = 1'b0;
        checks++; if (s_total_count !== 4'd0 || s_pal_count !== 4'd0) begin
            errors++; $display("FAIL sat_clear got %0d/%0d exp 0/0", s_total_count, s_pal_count); end
        @(posedge clk); @(negedge clk);
        checks++; if (s_total_count !== 4'd1 || s_pal_count !== 4'd1) begin
            errors++; $display("FAIL sat_after_clear got %0d/%0d exp 1/1", s_total_count, s_pal_count); end
        s_req_valid = '0;
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        rsp_ready = 1'b1;
        req_valid = 4'b0010;
        req_data[63:32] = 32'h1234_5678;
        @(posedge clk); @(negedge clk);
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin
            errors++; $display("FAIL mid_setup got v%0b id%0d exp v1 id1", rsp_valid, rsp_id); end
        req_valid = '0;
        rsp_ready = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0 || rsp_id !== '0 || rsp_data !== '0) begin
            errors++; $display("FAIL mid_async got v%0b id%0d data %h exp v0 id0 0", rsp_valid, rsp_id, rsp_data); end
        @(negedge clk);
        resetn = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 4'b1010;
        req_data[127:96] = 32'h0000_0003;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL mid_first_grant got %b exp 0010", req_ready); end
        @(posedge clk); @(negedge clk);
        req_valid = 4'b1000;
        checks++; if (rsp_id !== 2'd1 || total_count !== 16'd0) begin
            errors++; $display("FAIL mid_after got id%0d total %0d exp id1 total 0", rsp_id, total_count); end
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL mid_second_grant got %b exp 1000", req_ready); end
        @(posedge clk); @(negedge clk);
        req_valid = '0;
    endtask

    task automatic test_random();
        logic [DW-1:0] pdata [NR];
        bit            pend  [NR];
        int            m_ptr, m_id, m_total, m_palc, g;
        bit            m_valid, hs;
        logic          m_pal;
        logic [DW-1:0] m_data;
        logic [NR-1:0] exp_ready;
        logic [15:0]   h, hr;
        do_reset();
        for (int i = 0; i < NR; i++) begin pend[i] = 0; pdata[i] = '0; end
        m_ptr = 0; m_id = 0; m_total = 0; m_palc = 0; m_valid = 0; m_pal = 0; m_data = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < NR; i++) begin
                if (!pend[i] && ($urandom % 2) == 1) begin
                    pend[i] = 1;
                    if (($urandom % 3) == 0) begin
                        h = 16'($urandom); hr = {<<{h}};
                        pdata[i] = {hr, h};
                    end else begin
                        pdata[i] = $urandom;
                    end
                end
                req_valid[i] = pend[i];
                req_data[i*DW +: DW] = pdata[i];
            end
            rsp_ready  = ($urandom % 4) != 0;
            stat_clear = ($urandom % 40) == 0;
            #1;
            g = -1;
            if (!m_valid || rsp_ready) begin
                for (int k = 0; k < NR; k++) begin
                    if (g < 0 && pend[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
                end
            end
            exp_ready = (g >= 0) ? 4'(1 << g) : 4'b0000;
            checks++; if (req_ready !== exp_ready) begin
                errors++; $display("FAIL rand_ready cycle %0d got %b exp %b", cyc, req_ready, exp_ready); end
            @(posedge clk);
            hs = m_valid && rsp_ready;
            if (stat_clear) begin
                m_total = 0; m_palc = 0;
            end else if (hs) begin
                if (m_total < 65535) m_total++;
                if (m_pal && m_palc < 65535) m_palc++;
            end
            if (g >= 0) begin
                m_valid = 1; m_id = g; m_data = pdata[g]; m_pal = ref_pal(pdata[g]);
                m_ptr = (g + 1) % NR; pend[g] = 0;
            end else if (hs) begin
                m_valid = 0;
            end
            @(negedge clk);
            checks++; if (rsp_valid !== m_valid) begin
                errors++; $display("FAIL rand_valid cycle %0d got %0b exp %0b", cyc, rsp_valid, m_valid); end
            if (m_valid) begin
                checks++; if (rsp_id !== 2'(m_id) || rsp_data !== m_data || rsp_is_pal !== m_pal) begin
                    errors++; $display("FAIL rand_rsp cycle %0d got id%0d data %h pal%0b exp id%0d data %h pal%0b",
                                       cyc, rsp_id, rsp_data, rsp_is_pal, m_id, m_data, m_pal); end
            end
            checks++; if (total_count !== 16'(m_total) || pal_count !== 16'(m_palc)) begin
                errors++; $display("FAIL rand_counts cycle %0d got %0d/%0d exp %0d/%0d", cyc, total_count, pal_count, m_total, m_palc); end
        end
        clear_inputs();
    endtask

    initial begin
        resetn = 1'b0;
        clear_inputs();
        @(negedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_widths();
        test_saturate();
        test_reset_mid_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
